spacewar_input_ctrl: RTL and testbench

- Input-conditioning stage directly upstream of the tt_um_spacewar game core.
- Takes the eight raw player buttons from the dedicated input pins: two players × {rotate-left, rotate-right, thrust, fire}.
- Synchronises and debounces them, then turns them into game-ready per-frame controls: ship heading, thrust level, rate-limited fire pulses.
- Steps only on the frame tick from the video timing generator, so game physics is frame-locked.

---
 rtl/spacewar_input_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_spacewar_input_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spacewar_input_ctrl.sv
// ---------------------------------------------------------------------------
// spacewar_input_ctrl
//
// Input-conditioning stage in front of the spacewar game core. The eight raw
// player buttons are synchronised, debounced and then turned into
// frame-locked game controls: ship heading, thrust level and rate-limited
// fire (and optionally hyperspace) pulses.
//
// Parameters
//   DEB_CNT        clk cycles a synced input must hold a new value (>= 2)
//   ROT_PERIOD     frame ticks between heading steps while rotating (>= 1)
//   FIRE_COOLDOWN  frame ticks between shots of one player (>= 1)
//   HEADING_W      heading width, 2**HEADING_W directions
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   btn_in[7:0]  raw buttons, active high; per player {fire,thrust,rotr,rotl},
//                P0 in [3:0], P1 in [7:4]
//   frame_tick   one-clk strobe per video frame
//   btn_state    debounced button levels
//   heading0/1   per-player heading
//   thrust[1:0]  per-player thrust level, [0] = P0
//   fire_pulse   one-clk shot request per player
//   hyper_pulse  one-clk hyperspace request per player
//
// Build option
//   SPACEWAR_HYPERSPACE_EN  when defined, rotl+rotr+fire held together asks
//                           for hyperspace instead of a shot; when undefined
//                           hyper_pulse is tied low and the combination
//                           fires normally.
// ---------------------------------------------------------------------------
module spacewar_input_ctrl #(
    parameter int unsigned DEB_CNT       = 1000,
    parameter int unsigned ROT_PERIOD    = 4,
    parameter int unsigned FIRE_COOLDOWN = 8,
    parameter int unsigned HEADING_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           btn_in,
    input  logic                 frame_tick,
    output logic [7:0]           btn_state,
    output logic [HEADING_W-1:0] heading0,
    output logic [HEADING_W-1:0] heading1,
    output logic [1:0]           thrust,
    output logic [1:0]           fire_pulse,
    output logic [1:0]           hyper_pulse
);

    localparam int unsigned NUM_BTN    = 8;
    localparam int unsigned NUM_PLAYER = 2;
    localparam int unsigned DEB_W      = $clog2(DEB_CNT);
    localparam int unsigned ROT_W      = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
    localparam int unsigned FCD_W      = $clog2(FIRE_COOLDOWN + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_PERIOD - 1);
    // Cooldown holds the number of ticks still blocked after a shot, so a
    // held button repeats exactly every FIRE_COOLDOWN ticks.
    localparam logic [FCD_W-1:0] FCD_LOAD = FCD_W'(FIRE_COOLDOWN - 1);

    // One player's debounced button group, in btn_in bit order.
    typedef struct packed {
        logic fire;
        logic thrust;
        logic rotr;
        logic rotl;
    } player_btn_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser per button
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a synced mismatch must persist DEB_CNT cycles to be taken
    // ------------------------------------------------------------------
    logic [DEB_W-1:0]   deb_cnt     [NUM_BTN];
    logic [DEB_W-1:0]   deb_cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] btn_state_nxt;

    always_comb begin
        btn_state_nxt = btn_state;
        for (int i = 0; i < NUM_BTN; i++) begin
            deb_cnt_nxt[i] = '0;
            if (sync2[i] != btn_state[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    btn_state_nxt[i] = sync2[i];
                end else begin
                    deb_cnt_nxt[i] = deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_state <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            btn_state <= btn_state_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt[i] <= deb_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame-locked player logic
    // ------------------------------------------------------------------
    logic [HEADING_W-1:0]  heading_q   [NUM_PLAYER];
    logic [HEADING_W-1:0]  heading_nxt [NUM_PLAYER];
    logic [ROT_W-1:0]      rot_cnt     [NUM_PLAYER];
    logic [ROT_W-1:0]      rot_cnt_nxt [NUM_PLAYER];
    logic [FCD_W-1:0]      fire_cd     [NUM_PLAYER];
    logic [FCD_W-1:0]      fire_cd_nxt [NUM_PLAYER];
    logic [NUM_PLAYER-1:0] thrust_nxt;
    logic [NUM_PLAYER-1:0] fire_nxt;
    logic [NUM_PLAYER-1:0] fire_req;
    player_btn_t           pb;

`ifdef SPACEWAR_HYPERSPACE_EN
    localparam int unsigned      HCD_W    = $clog2(4 * FIRE_COOLDOWN + 1);
    localparam logic [HCD_W-1:0] HCD_LOAD = HCD_W'(4 * FIRE_COOLDOWN - 1);

    logic [HCD_W-1:0]      hyper_cd     [NUM_PLAYER];
    logic [HCD_W-1:0]      hyper_cd_nxt [NUM_PLAYER];
    logic [NUM_PLAYER-1:0] hyper_nxt;
    logic [NUM_PLAYER-1:0] hyper_req;

    // Hyperspace combo: while held it replaces firing entirely.
    always_comb begin
        hyper_nxt = '0;
        hyper_req = '0;
        fire_req  = '0;
        for (int p = 0; p < NUM_PLAYER; p++) begin
            hyper_cd_nxt[p] = hyper_cd[p];
            hyper_req[p] = btn_state[4*p] & btn_state[4*p+1] & btn_state[4*p+3];
            fire_req[p]  = btn_state[4*p+3] & ~hyper_req[p];
            if (frame_tick) begin
                if (hyper_req[p] && (hyper_cd[p] == '0)) begin
                    hyper_nxt[p]    = 1'b1;
                    hyper_cd_nxt[p] = HCD_LOAD;
                end else if (hyper_cd[p] != '0) begin
                    hyper_cd_nxt[p] = hyper_cd[p] - HCD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hyper_pulse <= '0;
            for (int p = 0; p < NUM_PLAYER; p++) begin
                hyper_cd[p] <= '0;
            end
        end else begin
            hyper_pulse <= hyper_nxt;
            for (int p = 0; p < NUM_PLAYER; p++) begin
                hyper_cd[p] <= hyper_cd_nxt[p];
            end
        end
    end
`else
    always_comb begin
        fire_req = '0;
        for (int p = 0; p < NUM_PLAYER; p++) begin
            fire_req[p] = btn_state[4*p+3];
        end
    end

    assign hyper_pulse = '0;
`endif

    // Rotation, thrust and fire next-state; nothing moves off a tick.
    always_comb begin
        pb         = '0;
        thrust_nxt = thrust;
        fire_nxt   = '0;
        for (int p = 0; p < NUM_PLAYER; p++) begin
            heading_nxt[p] = heading_q[p];
            rot_cnt_nxt[p] = rot_cnt[p];
            fire_cd_nxt[p] = fire_cd[p];
            if (frame_tick) begin
                pb = player_btn_t'(btn_state[4*p +: 4]);

                // Exactly one rotate button: step on the first tick of each
                // ROT_PERIOD window; neither or both restarts the window.
                if (pb.rotl ^ pb.rotr) begin
                    if (rot_cnt[p] == '0) begin
                        heading_nxt[p] = pb.rotr ? heading_q[p] + HEADING_W'(1)
                                                 : heading_q[p] - HEADING_W'(1);
                    end
                    rot_cnt_nxt[p] = (rot_cnt[p] == ROT_LAST) ? '0
                                                              : rot_cnt[p] + ROT_W'(1);
                end else begin
                    rot_cnt_nxt[p] = '0;
                end

                thrust_nxt[p] = pb.thrust;

                if (fire_req[p] && (fire_cd[p] == '0)) begin
                    fire_nxt[p]    = 1'b1;
                    fire_cd_nxt[p] = FCD_LOAD;
                end else if (fire_cd[p] != '0) begin
                    fire_cd_nxt[p] = fire_cd[p] - FCD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thrust     <= '0;
            fire_pulse <= '0;
            for (int p = 0; p < NUM_PLAYER; p++) begin
                heading_q[p] <= '0;
                rot_cnt[p]   <= '0;
                fire_cd[p]   <= '0;
            end
        end else begin
            thrust     <= thrust_nxt;
            fire_pulse <= fire_nxt;
            for (int p = 0; p < NUM_PLAYER; p++) begin
                heading_q[p] <= heading_nxt[p];
                rot_cnt[p]   <= rot_cnt_nxt[p];
                fire_cd[p]   <= fire_cd_nxt[p];
            end
        end
    end

    assign heading0 = heading_q[0];
    assign heading1 = heading_q[1];

endmodule

// File: tb/tb_spacewar_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spacewar_input_ctrl
//
// Directed scenarios followed by a random phase, all compared every cycle
// against a behavioural model: debounce as "the last DEB_CNT synced samples
// all disagree with the current level", rotation as a count of consecutive
// rotating ticks, fire/hyperspace as distance in ticks since the last shot.
// ---------------------------------------------------------------------------
module tb_spacewar_input_ctrl;

    localparam int DEB = 4;
    localparam int RP  = 4;
    localparam int FC  = 8;
    localparam int HW  = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    btn_in;
    logic          frame_tick;
    logic [7:0]    btn_state;
    logic [HW-1:0] heading0;
    logic [HW-1:0] heading1;
    logic [1:0]    thrust;
    logic [1:0]    fire_pulse;
    logic [1:0]    hyper_pulse;

    spacewar_input_ctrl #(
        .DEB_CNT       (DEB),
        .ROT_PERIOD    (RP),
        .FIRE_COOLDOWN (FC),
        .HEADING_W     (HW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .frame_tick  (frame_tick),
        .btn_state   (btn_state),
        .heading0    (heading0),
        .heading1    (heading1),
        .thrust      (thrust),
        .fire_pulse  (fire_pulse),
        .hyper_pulse (hyper_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    logic [7:0]    hist [0:7];
    logic [7:0]    m_state;
    logic [HW-1:0] m_head [2];
    logic [1:0]    m_thrust;
    logic [1:0]    m_fire;
    logic [1:0]    m_hyper;
    int            tick_no;
    int            last_fire  [2];
    int            last_hyper [2];
    int            run        [2];
    logic [3:0]    mb;
    logic          flip;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) hist[k] = '0;
            m_state  = '0;
            m_thrust = '0;
            m_fire   = '0;
            m_hyper  = '0;
            tick_no  = 0;
            for (int p = 0; p < 2; p++) begin
                m_head[p]     = '0;
                last_fire[p]  = -1000;
                last_hyper[p] = -1000;
                run[p]        = 0;
            end
        end else begin
            m_fire  = '0;
            m_hyper = '0;
            if (frame_tick) begin
                tick_no++;
                for (int p = 0; p < 2; p++) begin
                    mb = m_state[4*p +: 4];
                    if (mb[0] ^ mb[1]) begin
                        run[p]++;
                        if ((run[p] - 1) % RP == 0)
                            m_head[p] = mb[1] ? m_head[p] + HW'(1) : m_head[p] - HW'(1);
                    end else begin
                        run[p] = 0;
                    end
                    m_thrust[p] = mb[2];
`ifdef SPACEWAR_HYPERSPACE_EN
                    if (mb[0] && mb[1] && mb[3]) begin
                        if (tick_no - last_hyper[p] >= 4 * FC) begin
                            m_hyper[p]    = 1'b1;
                            last_hyper[p] = tick_no;
                        end
                    end else if (mb[3] && (tick_no - last_fire[p] >= FC)) begin
                        m_fire[p]    = 1'b1;
                        last_fire[p] = tick_no;
                    end
`else
                    if (mb[3] && (tick_no - last_fire[p] >= FC)) begin
                        m_fire[p]    = 1'b1;
                        last_fire[p] = tick_no;
                    end
`endif
                end
            end
            // hist[k] is the raw value sampled k edges ago; the debouncer
            // sees raw delayed by two edges through the synchroniser.
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn_in;
            for (int i = 0; i < 8; i++) begin
                flip = 1'b1;
                for (int k = 2; k < 2 + DEB; k++)
                    if (hist[k][i] == m_state[i]) flip = 1'b0;
                if (flip) m_state[i] = ~m_state[i];
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("btn_state",   64'(btn_state),   64'(m_state));
        chk("heading0",    64'(heading0),    64'(m_head[0]));
        chk("heading1",    64'(heading1),    64'(m_head[1]));
        chk("thrust",      64'(thrust),      64'(m_thrust));
        chk("fire_pulse",  64'(fire_pulse),  64'(m_fire));
        chk("hyper_pulse", 64'(hyper_pulse), 64'(m_hyper));
    endtask

    task automatic cycle(input logic tick);
        frame_tick = tick;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [63:0] mask_a;
    logic [63:0] mask_b;
    logic        seen;
    int          lat;

    initial begin
        rst_n      = 1'b0;
        btn_in     = '0;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_btn_state", 64'(btn_state), 64'd0);
        chk("rst_heading0",  64'(heading0),  64'd0);
        chk("rst_fire",      64'(fire_pulse), 64'd0);
        idle(2);

        // Debounce: 3-clk glitch is rejected
        btn_in = 8'h04;
        idle(3);
        btn_in = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0);
            seen = seen | btn_state[2];
        end
        chk("glitch_rejected", 64'(seen), 64'd0);

        // Debounce latency from rise to btn_state
        btn_in = 8'h04;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0);
            if (btn_state[2]) begin
                lat = k;
                break;
            end
        end
        chk("deb_latency", 64'(lat), 64'd6);
        cycle(1'b1);
        chk("thrust_p0", 64'(thrust), 64'd1);

        // Rotation wrap downward from 0
        btn_in = 8'h01;
        idle(8);
        for (int t = 1; t <= 9; t++) begin
            cycle(1'b1);
            if (t == 1) chk("rotl_t1", 64'(heading0), 64'd15);
            if (t == 5) chk("rotl_t5", 64'(heading0), 64'd14);
            if (t == 9) chk("rotl_t9", 64'(heading0), 64'd13);
            cycle(1'b0);
        end
        btn_in = 8'h03;
        idle(8);
        for (int t = 0; t < 3; t++) cycle(1'b1);
        chk("both_rot_hold", 64'(heading0), 64'd13);

        // Fire cooldown for P1
        btn_in = 8'h80;
        idle(8);
        mask_a = '0;
        seen   = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            cycle(1'b1);
            mask_a[t-1] = fire_pulse[1];
            seen = seen | fire_pulse[0];
            cycle(1'b0);
            seen = seen | fire_pulse[0];
        end
        chk("fire_p1_ticks", mask_a, 64'h0000_0000_0001_0101);
        chk("fire_p0_quiet", 64'(seen), 64'd0);

        // Simultaneous P0 rotr + P1 fire
        btn_in = 8'h00;
        idle(8);
        for (int t = 0; t < 8; t++) cycle(1'b1);
        btn_in = 8'h82;
        idle(8);
        cycle(1'b1);
        chk("simul_heading0", 64'(heading0), 64'd14);
        chk("simul_fire1",    64'(fire_pulse), 64'b10);

        // Hyperspace combo on P0
        btn_in = 8'h00;
        idle(8);
        for (int t = 0; t < 8; t++) cycle(1'b1);
        btn_in = 8'h0B;
        idle(8);
        mask_a = '0;
        mask_b = '0;
        for (int t = 1; t <= 34; t++) begin
            cycle(1'b1);
            mask_a[t-1] = hyper_pulse[0];
            mask_b[t-1] = fire_pulse[0];
            cycle(1'b0);
        end
`ifdef SPACEWAR_HYPERSPACE_EN
        chk("hyper_ticks", mask_a, 64'h0000_0001_0000_0001);
        chk("hyper_fire",  mask_b, 64'h0);
`else
        chk("hyper_ticks", mask_a, 64'h0);
        chk("hyper_fire",  mask_b, 64'h0000_0001_0101_0101);
`endif

        // Steer headings to 5/9 and reset asynchronously mid-run
        btn_in = 8'h00;
        idle(8);
        btn_in = 8'h12;
        idle(8);
        for (int t = 0; t < 64 && m_head[0] != HW'(5); t++) cycle(1'b1);
        chk("pre_rst_heading0", 64'(heading0), 64'd5);
        chk("pre_rst_heading1", 64'(heading1), 64'd9);
        btn_in = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_btn_state", 64'(btn_state), 64'd0);
        chk("async_heading0",  64'(heading0),  64'd0);
        chk("async_heading1",  64'(heading1),  64'd0);
        chk("async_thrust",    64'(thrust),    64'd0);
        chk("async_fire",      64'(fire_pulse), 64'd0);
        chk("async_hyper",     64'(hyper_pulse), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0);
            chk("post_rst_hold", 64'(btn_state), 64'd0);
        end
        cycle(1'b0);
        chk("post_rst_take", 64'(btn_state), 64'hFF);

        // Random phase against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) btn_in = btn_in ^ 8'($urandom);
            cycle($urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
